// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions: FSM states, frame constants and bit-period helper.
// Used by both the receiver and the transmitter so a TX/RX pair stays consistent.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

    // Clock cycles per bit; callers must keep the result >= 8.
    function automatic int calc_divisor(input int sysclk, input int baudrate);
        return sysclk / baudrate;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs with a configurable reset level.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling from a half-period offset after the start edge,
// one-cycle strobes for good frames and framing errors, break detection.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYSCLK   = 100_000_000,
    parameter int BAUDRATE = 57600,
    parameter int DIVISOR  = calc_divisor(SYSCLK, BAUDRATE)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       o_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIVISOR - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    logic                 rxd_s;
    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [7:0]           data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 busy_q;
    logic                 tick;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rxd),
        .q_o (rxd_s)
    );

    assign tick = (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rxd_s) begin
                        cnt_q   <= HALF_LOAD;
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (!tick) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (!rxd_s) begin
                        cnt_q   <= FULL_LOAD;
                        idx_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        // Line went back high before mid-start: treat as noise.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                DATA: begin
                    if (!tick) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
                        cnt_q   <= FULL_LOAD;
                        idx_q   <= idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (!tick) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (rxd_s == STOP_LEVEL) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        ferr_q  <= 1'b1;
                        state_q <= BREAK;
                    end
                end
                BREAK: begin
                    // Hold here until the line idles so a long low produces one error only.
                    if (rxd_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign o_valid   = valid_q;
    assign frame_err = ferr_q;
    assign rx_busy   = busy_q;

endmodule
